// File: rtl/mc_banked_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_banked_memory_if
// Brief    : Per-channel request/response bus of the banked memory. Every
//            field is packed with one slice per channel.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_banked_memory_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH-1:0]            valid;
    logic [NUM_CH-1:0]            ready;
    logic [NUM_CH-1:0]            wr_rd;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*WIDTH-1:0]      wdata;
    logic [NUM_CH*WIDTH/8-1:0]    wstrb;
    logic [NUM_CH-1:0]            rvalid;
    logic [NUM_CH*WIDTH-1:0]      rdata;
    logic [NUM_CH-1:0]            err;

    // Requester side.
    modport master (
        output valid, wr_rd, addr, wdata, wstrb,
        input  ready, rvalid, rdata, err
    );

    // Memory side.
    modport slave (
        input  valid, wr_rd, addr, wdata, wstrb,
        output ready, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/mc_banked_memory.sv
`default_nettype none
// ============================================================================
// Module   : mc_banked_memory
// Brief    : Single-ported storage shared by NUM_CH request channels through a
//            round-robin arbiter. Byte-strobed writes, fixed-latency pipelined
//            reads, out-of-range error pulses, and a hardware clear sweep that
//            runs after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module mc_banked_memory #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 64,
    parameter int              ADDR_WIDTH = 6,
    parameter int              NUM_CH     = 2,
    parameter int              RD_LAT     = 1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  wire               clk,
    input  wire               res,
    mc_banked_memory_if.slave bus,
    output logic              init_done
);
    localparam int C_NB  = WIDTH / 8;
    localparam int C_CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [C_CHW-1:0]      C_LAST_CH = C_CHW'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;

    logic [WIDTH-1:0]      r_mem [DEPTH];

    // Arbitration
    logic [C_CHW-1:0]      r_last;
    logic [C_CHW-1:0]      w_cand;
    logic                  w_gnt_any;
    logic [C_CHW-1:0]      w_gnt_ch;
    logic [NUM_CH-1:0]     w_ready;

    // Fields of the granted request
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_wr;
    logic [WIDTH-1:0]      w_sel_wdata;
    logic [C_NB-1:0]       w_sel_wstrb;
    logic                  w_in_range;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic [WIDTH-1:0]      w_rd_word;

    // Response leaving the read delay line
    logic                  w_rsp_v;
    logic [C_CHW-1:0]      w_rsp_ch;
    logic                  w_rsp_oor;
    logic [WIDTH-1:0]      w_rsp_data;

    // Registered per-channel outputs
    logic [NUM_CH-1:0]       r_rvalid;
    logic [NUM_CH-1:0]       r_err;
    logic [NUM_CH*WIDTH-1:0] r_rdata;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------

    // State register: any reset returns to the clear sweep.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT in the same edge that clears the last word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_cnt == C_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Sweep counter and completion flag; done rises together with RUN.
    always_ff @(posedge clk) begin
        if (res) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            if (r_init_cnt == C_LAST) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign init_done = r_init_done;

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------

    // Grant the first valid channel after the last winner; nothing during
    // reset or the sweep, so ready can never be high there.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_ch  = '0;
        w_cand    = '0;
        if ((r_state == ST_RUN) && !res) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                w_cand = C_CHW'((int'(r_last) + k) % NUM_CH);
                if (!w_gnt_any && bus.valid[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_ch  = w_cand;
                end
            end
        end
    end

    // One-hot ready derived from the grant; it implies the matching valid.
    always_comb begin
        w_ready = '0;
        if (w_gnt_any) begin
            w_ready[w_gnt_ch] = 1'b1;
        end
    end

    assign bus.ready = w_ready;

    // Remember the winner so the next search starts just after it.
    always_ff @(posedge clk) begin
        if (res) begin
            r_last <= C_LAST_CH;
        end else if (w_gnt_any) begin
            r_last <= w_gnt_ch;
        end
    end

    // ------------------------------------------------------------------------
    // Request decode and storage
    // ------------------------------------------------------------------------

    // Pull the granted channel's fields out of the packed buses.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wr    = 1'b0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_ch == C_CHW'(i)) begin
                w_sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wr    = bus.wr_rd[i];
                w_sel_wdata = bus.wdata[i*WIDTH +: WIDTH];
                w_sel_wstrb = bus.wstrb[i*C_NB +: C_NB];
            end
        end
    end

    assign w_in_range = ({1'b0, w_sel_addr} < C_DEPTH);
    assign w_acc_wr   = w_gnt_any & w_sel_wr;
    assign w_acc_rd   = w_gnt_any & ~w_sel_wr;
    // Out-of-range reads return zero and never touch the array.
    assign w_rd_word  = w_in_range ? r_mem[w_sel_addr] : '0;

    // Single write port: the clear sweep owns it in INIT, accepted in-range
    // writes own it in RUN, each byte lane gated by its strobe.
    always_ff @(posedge clk) begin
        if (!res) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_cnt] <= INIT_VAL;
            end else if (w_acc_wr && w_in_range) begin
                for (int b = 0; b < C_NB; b++) begin
                    if (w_sel_wstrb[b]) begin
                        r_mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read delay line: the output register is the last stage, so only
    // RD_LAT-1 intermediate stages are needed.
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_rsp_v    = w_acc_rd;
            assign w_rsp_ch   = w_gnt_ch;
            assign w_rsp_oor  = ~w_in_range;
            assign w_rsp_data = w_rd_word;
        end else begin : g_latn
            logic             r_pv    [RD_LAT-1];
            logic [C_CHW-1:0] r_pch   [RD_LAT-1];
            logic             r_poor  [RD_LAT-1];
            logic [WIDTH-1:0] r_pdata [RD_LAT-1];

            // Shift accepted reads along; reset drops everything in flight.
            always_ff @(posedge clk) begin
                if (res) begin
                    for (int j = 0; j < RD_LAT-1; j++) begin
                        r_pv[j]    <= 1'b0;
                        r_pch[j]   <= '0;
                        r_poor[j]  <= 1'b0;
                        r_pdata[j] <= '0;
                    end
                end else begin
                    r_pv[0]    <= w_acc_rd;
                    r_pch[0]   <= w_gnt_ch;
                    r_poor[0]  <= ~w_in_range;
                    r_pdata[0] <= w_rd_word;
                    for (int j = 1; j < RD_LAT-1; j++) begin
                        r_pv[j]    <= r_pv[j-1];
                        r_pch[j]   <= r_pch[j-1];
                        r_poor[j]  <= r_poor[j-1];
                        r_pdata[j] <= r_pdata[j-1];
                    end
                end
            end

            assign w_rsp_v    = r_pv[RD_LAT-2];
            assign w_rsp_ch   = r_pch[RD_LAT-2];
            assign w_rsp_oor  = r_poor[RD_LAT-2];
            assign w_rsp_data = r_pdata[RD_LAT-2];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Per-channel response registers
    // ------------------------------------------------------------------------

    // Route responses to their owner; rdata holds between responses. err is
    // the read-error of a response or the write-error of this cycle's accept.
    always_ff @(posedge clk) begin
        if (res) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_rvalid[i] <= w_rsp_v && (w_rsp_ch == C_CHW'(i));
                r_err[i]    <= (w_rsp_v && (w_rsp_ch == C_CHW'(i)) && w_rsp_oor) ||
                               (w_acc_wr && !w_in_range && (w_gnt_ch == C_CHW'(i)));
                if (w_rsp_v && (w_rsp_ch == C_CHW'(i))) begin
                    r_rdata[i*WIDTH +: WIDTH] <= w_rsp_data;
                end
            end
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;
    assign bus.rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mc_banked_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_banked_memory
// Brief    : Directed bench for mc_banked_memory. Instance A: DEPTH=64,
//            RD_LAT=1. Instance B: DEPTH=48, RD_LAT=3. Two channels each.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_banked_memory;
    localparam int W  = 32;
    localparam int AW = 6;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res_a;
    logic res_b;
    logic done_a;
    logic done_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    mc_banked_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus_a ();
    mc_banked_memory_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus_b ();

    mc_banked_memory #(.WIDTH(W), .DEPTH(64), .ADDR_WIDTH(AW), .NUM_CH(NC),
                       .RD_LAT(1), .INIT_VAL('0)) dut_a (
        .clk(clk), .res(res_a), .bus(bus_a.slave), .init_done(done_a));

    mc_banked_memory #(.WIDTH(W), .DEPTH(48), .ADDR_WIDTH(AW), .NUM_CH(NC),
                       .RD_LAT(3), .INIT_VAL('0)) dut_b (
        .clk(clk), .res(res_b), .bus(bus_b.slave), .init_done(done_b));

    // Drive all request fields of one instance.
    task automatic drive(input int sel, input logic [NC-1:0] v, input logic [NC-1:0] wr,
                         input logic [NC*AW-1:0] a, input logic [NC*W-1:0] wd,
                         input logic [NC*W/8-1:0] ws);
        if (sel == 0) begin
            bus_a.valid = v; bus_a.wr_rd = wr; bus_a.addr = a; bus_a.wdata = wd; bus_a.wstrb = ws;
        end else begin
            bus_b.valid = v; bus_b.wr_rd = wr; bus_b.addr = a; bus_b.wdata = wd; bus_b.wstrb = ws;
        end
    endtask

    // Snapshot all outputs of one instance.
    task automatic sample(input int sel, output logic [NC-1:0] rdy, output logic [NC-1:0] rv,
                          output logic [NC-1:0] er, output logic [NC*W-1:0] rd, output logic dn);
        if (sel == 0) begin
            rdy = bus_a.ready; rv = bus_a.rvalid; er = bus_a.err; rd = bus_a.rdata; dn = done_a;
        end else begin
            rdy = bus_b.ready; rv = bus_b.rvalid; er = bus_b.err; rd = bus_b.rdata; dn = done_b;
        end
    endtask

    // One request on one channel. Returns acceptance, read latency in cycles
    // after the accepting edge (0 = no response), read data and the err bit
    // (for writes: err in the cycle after acceptance).
    task automatic xact(input int sel, input int ch, input logic wr, input logic [AW-1:0] a,
                        input logic [W-1:0] wd, input logic [3:0] ws,
                        output logic [W-1:0] rd_data, output logic er, output int lat,
                        output logic acc);
        logic [NC-1:0]     rdy, rv, e, v;
        logic [NC*W-1:0]   rd, wdv;
        logic [NC*AW-1:0]  av;
        logic [NC*W/8-1:0] wsv;
        logic              dn;
        v = '0; v[ch] = 1'b1;
        av = '0; av[ch*AW +: AW] = a;
        wdv = '0; wdv[ch*W +: W] = wd;
        wsv = '0; wsv[ch*4 +: 4] = ws;
        rd_data = '0; er = 1'b0; lat = 0; acc = 1'b0;
        @(posedge clk); #1;
        drive(sel, v, wr ? v : '0, av, wdv, wsv);
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            sample(sel, rdy, rv, e, rd, dn);
            if (rdy[ch]) acc = 1'b1;
            @(posedge clk); #1;
        end
        drive(sel, '0, '0, '0, '0, '0);
        if (acc) begin
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                sample(sel, rdy, rv, e, rd, dn);
                if (wr) begin
                    if (k == 1) er = e[ch];
                end else if (rv[ch] && lat == 0) begin
                    lat = k; rd_data = rd[ch*W +: W]; er = e[ch];
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [NC-1:0] rdy, rv, e;
        logic [NC*W-1:0] rd;
        logic dn;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sample(s, rdy, rv, e, rd, dn);
            n_cmp++; if (rdy !== 2'b00) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b want 00", s, rdy); end
            n_cmp++; if (rv !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid dut%0d: got %b want 00", s, rv); end
            n_cmp++; if (e !== 2'b00) begin n_bad++; $display("FAIL reset_err dut%0d: got %b want 00", s, e); end
            n_cmp++; if (rd !== 64'h0) begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", s, rd); end
            n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL reset_init_done dut%0d: got %b want 0", s, dn); end
        end
    endtask

    task automatic test_init_sweep();
        logic [W-1:0] d; logic er, acc, early; int lat, n;
        logic [NC-1:0] rdy, rv, e; logic [NC*W-1:0] rd; logic dn;
        xact(0, 0, 1'b1, 6'd0,  32'h12345678, 4'hF, d, er, lat, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL init_preload_accept: got %b want 1", acc); end
        xact(0, 1, 1'b1, 6'd17, 32'hA5A5A5A5, 4'hF, d, er, lat, acc);
        xact(0, 0, 1'b1, 6'd63, 32'h5A5A5A5A, 4'hF, d, er, lat, acc);
        xact(0, 1, 1'b0, 6'd17, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL init_preload_read: got %h want a5a5a5a5", d); end
        // One-cycle reset pulse with ch0 requesting a read of address 0.
        @(posedge clk); #1;
        res_a = 1'b1;
        drive(0, 2'b01, 2'b00, '0, '0, '0);
        @(posedge clk); #1;
        res_a = 1'b0;
        n = 0; early = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            sample(0, rdy, rv, e, rd, dn);
            if (dn) break;
            if (rdy !== 2'b00) early = 1'b1;
            n++;
        end
        n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL init_cycles: got %0d want 64", n); end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL init_ready_early: got %b want 0", early); end
        n_cmp++; if (rdy !== 2'b01) begin n_bad++; $display("FAIL init_first_grant: got %b want 01", rdy); end
        @(posedge clk); #1;
        drive(0, '0, '0, '0, '0, '0);
        @(negedge clk);
        sample(0, rdy, rv, e, rd, dn);
        n_cmp++; if (rv !== 2'b01) begin n_bad++; $display("FAIL init_rd0_rvalid: got %b want 01", rv); end
        n_cmp++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL init_rd0_data: got %h want 0", rd[31:0]); end
        xact(0, 0, 1'b0, 6'd17, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL init_rd17: got %h want 0", d); end
        xact(0, 1, 1'b0, 6'd63, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL init_rd63: got %h want 0", d); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL init_rd63_err: got %b want 0", er); end
    endtask

    task automatic test_write_read();
        logic [W-1:0] d; logic er, acc; int lat;
        for (int s = 0; s < 2; s++) begin
            xact(s, 0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, d, er, lat, acc);
            xact(s, 0, 1'b0, 6'd5, 32'h0, 4'h0, d, er, lat, acc);
            n_cmp++; if (lat !== ((s == 0) ? 1 : 3)) begin n_bad++; $display("FAIL wr_rd_latency dut%0d: got %0d want %0d", s, lat, (s == 0) ? 1 : 3); end
            n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_data dut%0d: got %h want deadbeef", s, d); end
            n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wr_rd_err dut%0d: got %b want 0", s, er); end
        end
    endtask

    task automatic test_strobe();
        logic [W-1:0] d; logic er, acc; int lat;
        xact(0, 0, 1'b1, 6'd5, 32'h11223344, 4'b0101, d, er, lat, acc);
        xact(0, 1, 1'b0, 6'd5, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'hDE22BE44) begin n_bad++; $display("FAIL strobe_merge: got %h want de22be44", d); end
        xact(0, 1, 1'b1, 6'd5, 32'h99999999, 4'b0000, d, er, lat, acc);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL strobe_zero_err: got %b want 0", er); end
        xact(0, 0, 1'b0, 6'd5, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'hDE22BE44) begin n_bad++; $display("FAIL strobe_zero_data: got %h want de22be44", d); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, exp_d, got_d; logic er, acc; int lat;
        logic [NC-1:0] rdy, rv, e, exp_rdy, prev; logic [NC*W-1:0] rd; logic dn;
        xact(0, 0, 1'b1, 6'd1, 32'hA1A10001, 4'hF, d, er, lat, acc);
        xact(0, 1, 1'b1, 6'd2, 32'hB2B20002, 4'hF, d, er, lat, acc);
        prev = '0;
        @(posedge clk); #1;
        drive(0, 2'b11, 2'b00, {6'd2, 6'd1}, '0, '0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            sample(0, rdy, rv, e, rd, dn);
            exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (rdy !== exp_rdy) begin n_bad++; $display("FAIL b2b_grant c%0d: got %b want %b", n, rdy, exp_rdy); end
            if (n > 0) begin
                exp_d = prev[0] ? 32'hA1A10001 : 32'hB2B20002;
                got_d = prev[0] ? rd[31:0] : rd[63:32];
                n_cmp++; if (rv !== prev) begin n_bad++; $display("FAIL b2b_rvalid c%0d: got %b want %b", n, rv, prev); end
                n_cmp++; if (got_d !== exp_d) begin n_bad++; $display("FAIL b2b_rdata c%0d: got %h want %h", n, got_d, exp_d); end
            end
            prev = exp_rdy;
            @(posedge clk); #1;
        end
        drive(0, '0, '0, '0, '0, '0);
        @(negedge clk);
        sample(0, rdy, rv, e, rd, dn);
        n_cmp++; if (rv !== 2'b10) begin n_bad++; $display("FAIL b2b_last_rvalid: got %b want 10", rv); end
        n_cmp++; if (rd !== {32'hB2B20002, 32'hA1A10001}) begin n_bad++; $display("FAIL b2b_hold: got %h want b2b20002a1a10001", rd); end
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] d; logic er, acc; int lat;
        xact(1, 1, 1'b1, 6'd2,  32'h02020202, 4'hF, d, er, lat, acc);
        xact(1, 0, 1'b1, 6'd47, 32'h47474747, 4'hF, d, er, lat, acc);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL oor_wr47_err: got %b want 0", er); end
        xact(1, 0, 1'b0, 6'd47, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h47474747) begin n_bad++; $display("FAIL oor_rd47: got %h want 47474747", d); end
        xact(1, 1, 1'b0, 6'd50, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_rd_latency: got %0d want 3", lat); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b want 1", er); end
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL oor_rd_data: got %h want 0", d); end
        xact(1, 0, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF, d, er, lat, acc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b want 1", er); end
        xact(1, 0, 1'b0, 6'd2, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h02020202) begin n_bad++; $display("FAIL oor_alias: got %h want 02020202", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] d; logic er, acc, seen; int lat, n;
        logic [NC-1:0] rdy, rv, e; logic [NC*W-1:0] rd; logic dn;
        xact(1, 0, 1'b1, 6'd10, 32'hCAFEF00D, 4'hF, d, er, lat, acc);
        @(posedge clk); #1;
        drive(1, 2'b01, 2'b00, {6'd0, 6'd10}, '0, '0);
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            sample(1, rdy, rv, e, rd, dn);
            if (rdy[0]) acc = 1'b1;
            @(posedge clk); #1;
        end
        drive(1, '0, '0, '0, '0, '0);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL midrst_accept: got %b want 1", acc); end
        seen = 1'b0;
        @(negedge clk);
        sample(1, rdy, rv, e, rd, dn);
        if (rv !== 2'b00) seen = 1'b1;
        @(posedge clk); #1;
        res_b = 1'b1;
        @(negedge clk);
        sample(1, rdy, rv, e, rd, dn);
        if (rv !== 2'b00) seen = 1'b1;
        @(posedge clk); #1;
        res_b = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            sample(1, rdy, rv, e, rd, dn);
            if (rv !== 2'b00) seen = 1'b1;
            if (dn) break;
            n++;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rvalid: got %b want 0", seen); end
        n_cmp++; if (n !== 48) begin n_bad++; $display("FAIL midrst_init_cycles: got %0d want 48", n); end
        xact(1, 0, 1'b0, 6'd10, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midrst_rd10: got %h want 0", d); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL midrst_rd10_latency: got %0d want 3", lat); end
        xact(1, 1, 1'b0, 6'd47, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midrst_rd47: got %h want 0", d); end
        xact(1, 0, 1'b0, 6'd2, 32'h0, 4'h0, d, er, lat, acc);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midrst_rd2: got %h want 0", d); end
    endtask

    initial begin
        res_a = 1'b1;
        res_b = 1'b1;
        drive(0, '0, '0, '0, '0, '0);
        drive(1, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        res_a = 1'b0;
        res_b = 1'b0;
        test_init_sweep();
        test_write_read();
        test_strobe();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
